reg_write_arbiter: RTL and testbench

REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

---
 rtl/reg_write_arbiter_pkg.sv | 19 +
 rtl/reg_write_arbiter_wq.sv | 54 +++++
 rtl/reg_write_arbiter.sv | 129 ++++++++++++
 tb/tb_reg_write_arbiter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_write_arbiter_pkg.sv
// Shared processor package: default widths of the register write path and
// the queued write entry layout.
package reg_write_arbiter_pkg;

  localparam int DW_DEF    = 16;
  localparam int AW_DEF    = 3;
  localparam int DEPTH_DEF = 2;

  typedef struct packed {
    logic [AW_DEF-1:0] dest;
    logic [DW_DEF-1:0] data;
  } wr_entry_t;

  typedef enum logic {
    GRANT_REQ0 = 1'b0,
    GRANT_REQ1 = 1'b1
  } grant_e;

endpackage

// File: rtl/reg_write_arbiter_wq.sv
// wq_fifo: per-requester write queue with wrap-around pointers and an extra
// pointer bit to tell full from empty; exposes every slot for the scoreboard.
module wq_fifo #(
  parameter int W     = 19,
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_push,
  input  logic [W-1:0]          i_data,
  input  logic                  i_pop,
  output logic [W-1:0]          o_head,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [DEPTH-1:0]      o_slotValid,
  output logic [DEPTH-1:0][W-1:0] o_slots
);

  localparam int PW = $clog2(DEPTH);

  logic [PW:0]             r_wrPtr;
  logic [PW:0]             r_rdPtr;
  logic [DEPTH-1:0][W-1:0] r_mem;
  logic [PW:0]             w_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (i_push) r_wrPtr <= r_wrPtr + 1'b1;
      if (i_pop)  r_rdPtr <= r_rdPtr + 1'b1;
    end
  end

  // Storage needs no reset: a slot is only observed while the pointers mark it valid.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wrPtr[PW-1:0]] <= i_data;
  end

  assign w_count = r_wrPtr - r_rdPtr;
  assign o_empty = (r_wrPtr == r_rdPtr);
  assign o_full  = (r_wrPtr[PW] != r_rdPtr[PW]) && (r_wrPtr[PW-1:0] == r_rdPtr[PW-1:0]);
  assign o_head  = r_mem[r_rdPtr[PW-1:0]];
  assign o_slots = r_mem;

  always_comb begin
    o_slotValid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      o_slotValid[i] = ({1'b0, PW'(i) - r_rdPtr[PW-1:0]} < w_count);
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter merging ALU and load writebacks into one registered
// register-file write port, with a pending-destination scoreboard.
module reg_write_arbiter
  import reg_write_arbiter_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int AW    = AW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [AW-1:0]     req0_dest,
  input  logic [DW-1:0]     req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [AW-1:0]     req1_dest,
  input  logic [DW-1:0]     req1_data,
  output logic              req1_ready,
  input  logic              hold,
  output logic              wr_en,
  output logic [AW-1:0]     wr_dest,
  output logic [DW-1:0]     wr_data,
  output logic [(1<<AW)-1:0] pending
);

  localparam int W = AW + DW;

  logic                    w_full0, w_full1;
  logic                    w_empty0, w_empty1;
  logic                    w_pop0, w_pop1;
  logic [W-1:0]            w_head0, w_head1, w_popEntry;
  logic [DEPTH-1:0]        w_valid0, w_valid1;
  logic [DEPTH-1:0][W-1:0] w_slots0, w_slots1;
  grant_e                  w_grant;
  grant_e                  r_lastGrant;
  logic                    r_wrEn;
  logic [AW-1:0]           r_wrDest;
  logic [DW-1:0]           r_wrData;
  logic [(1<<AW)-1:0]      w_pending;

  assign req0_ready = ~w_full0;
  assign req1_ready = ~w_full1;

  wq_fifo #(.W(W), .DEPTH(DEPTH)) u_wq0 (
    .clk        (clk),
    .rst        (rst),
    .i_push     (req0_valid & ~w_full0),
    .i_data     ({req0_dest, req0_data}),
    .i_pop      (w_pop0),
    .o_head     (w_head0),
    .o_full     (w_full0),
    .o_empty    (w_empty0),
    .o_slotValid(w_valid0),
    .o_slots    (w_slots0)
  );

  wq_fifo #(.W(W), .DEPTH(DEPTH)) u_wq1 (
    .clk        (clk),
    .rst        (rst),
    .i_push     (req1_valid & ~w_full1),
    .i_data     ({req1_dest, req1_data}),
    .i_pop      (w_pop1),
    .o_head     (w_head1),
    .o_full     (w_full1),
    .o_empty    (w_empty1),
    .o_slotValid(w_valid1),
    .o_slots    (w_slots1)
  );

  // On a contest the requester that lost last time wins; hold freezes pops and the flag.
  always_comb begin
    w_pop0  = 1'b0;
    w_pop1  = 1'b0;
    w_grant = r_lastGrant;
    if (!hold) begin
      if (!w_empty0 && !w_empty1) begin
        if (r_lastGrant == GRANT_REQ1) begin
          w_pop0  = 1'b1;
          w_grant = GRANT_REQ0;
        end else begin
          w_pop1  = 1'b1;
          w_grant = GRANT_REQ1;
        end
      end else if (!w_empty0) begin
        w_pop0  = 1'b1;
        w_grant = GRANT_REQ0;
      end else if (!w_empty1) begin
        w_pop1  = 1'b1;
        w_grant = GRANT_REQ1;
      end
    end
  end

  assign w_popEntry = w_pop1 ? w_head1 : w_head0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lastGrant <= GRANT_REQ1;
      r_wrEn      <= 1'b0;
      r_wrDest    <= '0;
      r_wrData    <= '0;
    end else if (w_pop0 || w_pop1) begin
      r_lastGrant <= w_grant;
      r_wrEn      <= (w_popEntry[DW +: AW] != '0);
      r_wrDest    <= w_popEntry[DW +: AW];
      r_wrData    <= w_popEntry[DW-1:0];
    end else begin
      r_wrEn      <= 1'b0;
    end
  end

  // Register 0 is hardwired, so it is never reported as pending.
  always_comb begin
    w_pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_valid0[i]) w_pending[w_slots0[i][DW +: AW]] = 1'b1;
      if (w_valid1[i]) w_pending[w_slots1[i][DW +: AW]] = 1'b1;
    end
    if (r_wrEn) w_pending[r_wrDest] = 1'b1;
    w_pending[0] = 1'b0;
  end

  assign wr_en   = r_wrEn;
  assign wr_dest = r_wrDest;
  assign wr_data = r_wrData;
  assign pending = w_pending;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Testbench for reg_write_arbiter: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_reg_write_arbiter;
  import reg_write_arbiter_pkg::*;

  localparam int DW    = DW_DEF;
  localparam int AW    = AW_DEF;
  localparam int DEPTH = DEPTH_DEF;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0Valid = 1'b0, req1Valid = 1'b0, hold = 1'b0;
  logic [AW-1:0] req0Dest = '0, req1Dest = '0;
  logic [DW-1:0] req0Data = '0, req1Data = '0;
  logic          req0Ready, req1Ready, wrEn;
  logic [AW-1:0] wrDest;
  logic [DW-1:0] wrData;
  logic [7:0]    pendingOut;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  wr_entry_t     mQ0[$];
  wr_entry_t     mQ1[$];
  logic          mLast = 1'b1;
  logic          mWrEn = 1'b0;
  logic [AW-1:0] mWrDest = '0;
  logic [DW-1:0] mWrData = '0;

  reg_write_arbiter #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req0_valid(req0Valid),
    .req0_dest (req0Dest),
    .req0_data (req0Data),
    .req0_ready(req0Ready),
    .req1_valid(req1Valid),
    .req1_dest (req1Dest),
    .req1_data (req1Data),
    .req1_ready(req1Ready),
    .hold      (hold),
    .wr_en     (wrEn),
    .wr_dest   (wrDest),
    .wr_data   (wrData),
    .pending   (pendingOut)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] modelPending();
    logic [7:0] p = '0;
    foreach (mQ0[i]) p[mQ0[i].dest] = 1'b1;
    foreach (mQ1[i]) p[mQ1[i].dest] = 1'b1;
    if (mWrEn) p[mWrDest] = 1'b1;
    p[0] = 1'b0;
    return p;
  endfunction

  task automatic modelReset();
    mQ0.delete();
    mQ1.delete();
    mLast   = 1'b1;
    mWrEn   = 1'b0;
    mWrDest = '0;
    mWrData = '0;
  endtask

  // One clock edge with the currently driven inputs; model advances in step.
  task automatic applyStimulus();
    bit        p0, p1;
    int        g;
    wr_entry_t e, n0, n1;
    p0 = req0Valid && (mQ0.size() < DEPTH);
    p1 = req1Valid && (mQ1.size() < DEPTH);
    n0.dest = req0Dest; n0.data = req0Data;
    n1.dest = req1Dest; n1.data = req1Data;
    g = -1;
    if (!hold) begin
      if (mQ0.size() > 0 && mQ1.size() > 0) g = mLast ? 0 : 1;
      else if (mQ0.size() > 0) g = 0;
      else if (mQ1.size() > 0) g = 1;
    end
    @(posedge clk);
    if (g == 0) e = mQ0.pop_front();
    else if (g == 1) e = mQ1.pop_front();
    if (g >= 0) begin
      mWrEn   = (e.dest != '0);
      mWrDest = e.dest;
      mWrData = e.data;
      mLast   = (g == 1);
    end else begin
      mWrEn = 1'b0;
    end
    if (p0) mQ0.push_back(n0);
    if (p1) mQ1.push_back(n1);
    #1;
  endtask

  task automatic resetDut();
    req0Valid = 1'b0; req1Valid = 1'b0; hold = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    modelReset();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    vectors++; if (wrEn !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_wr_en: got %0b expected 0", wrEn); end
    vectors++; if (wrDest !== '0) begin miscompares++; $display("[TB] FAIL reset_wr_dest: got %0h expected 0", wrDest); end
    vectors++; if (wrData !== '0) begin miscompares++; $display("[TB] FAIL reset_wr_data: got %0h expected 0", wrData); end
    vectors++; if (pendingOut !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_pending: got %0h expected 0", pendingOut); end
    vectors++; if ({req0Ready, req1Ready} !== 2'b11) begin miscompares++; $display("[TB] FAIL reset_ready: got %b expected 11", {req0Ready, req1Ready}); end
    rst = 1'b0;
    modelReset();
  endtask

  task automatic test_single();
    req0Valid = 1'b1; req0Dest = 3'd3; req0Data = 16'h1234;
    applyStimulus();
    req0Valid = 1'b0;
    vectors++; if (pendingOut !== 8'h08) begin miscompares++; $display("[TB] FAIL single_pending_queued: got %0h expected 08", pendingOut); end
    vectors++; if (wrEn !== 1'b0) begin miscompares++; $display("[TB] FAIL single_early_wr_en: got %0b expected 0", wrEn); end
    applyStimulus();
    vectors++; if ({wrEn, wrDest, wrData} !== {1'b1, 3'd3, 16'h1234}) begin
      miscompares++; $display("[TB] FAIL single_write: got en=%0b dest=%0d data=%0h expected en=1 dest=3 data=1234", wrEn, wrDest, wrData);
    end
    vectors++; if (pendingOut !== 8'h08) begin miscompares++; $display("[TB] FAIL single_pending_staged: got %0h expected 08", pendingOut); end
    applyStimulus();
    vectors++; if (wrEn !== 1'b0) begin miscompares++; $display("[TB] FAIL single_wr_en_drop: got %0b expected 0", wrEn); end
    vectors++; if (pendingOut !== 8'h00) begin miscompares++; $display("[TB] FAIL single_pending_clear: got %0h expected 0", pendingOut); end
  endtask

  task automatic test_round_robin();
    logic [AW-1:0] expDest [4];
    expDest = '{3'd1, 3'd5, 3'd2, 3'd6};
    resetDut();
    req0Valid = 1'b1; req1Valid = 1'b1;
    req0Dest = 3'd1; req0Data = 16'h0111; req1Dest = 3'd5; req1Data = 16'h0555;
    applyStimulus();
    req0Dest = 3'd2; req0Data = 16'h0222; req1Dest = 3'd6; req1Data = 16'h0666;
    applyStimulus();
    req0Valid = 1'b0; req1Valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      vectors++; if ({wrEn, wrDest} !== {1'b1, expDest[i]}) begin
        miscompares++; $display("[TB] FAIL rr_seq%0d: got en=%0b dest=%0d expected en=1 dest=%0d", i, wrEn, wrDest, expDest[i]);
      end
      applyStimulus();
    end
    vectors++; if (wrEn !== 1'b0) begin miscompares++; $display("[TB] FAIL rr_idle: got %0b expected 0", wrEn); end
  endtask

  task automatic test_hold_backpressure();
    hold = 1'b1; req1Valid = 1'b1;
    req1Dest = 3'd4; req1Data = 16'hB004; applyStimulus();
    req1Dest = 3'd5; req1Data = 16'hB005; applyStimulus();
    vectors++; if (req1Ready !== 1'b0) begin miscompares++; $display("[TB] FAIL hold_ready_full: got %0b expected 0", req1Ready); end
    req1Dest = 3'd6; req1Data = 16'hB006; applyStimulus();
    vectors++; if ({req1Ready, wrEn} !== 2'b00) begin miscompares++; $display("[TB] FAIL hold_frozen: got ready/en=%b expected 00", {req1Ready, wrEn}); end
    vectors++; if (pendingOut !== 8'h30) begin miscompares++; $display("[TB] FAIL hold_pending: got %0h expected 30", pendingOut); end
    hold = 1'b0;
    applyStimulus();
    vectors++; if ({wrEn, wrDest, wrData} !== {1'b1, 3'd4, 16'hB004}) begin miscompares++; $display("[TB] FAIL hold_retire0: got en=%0b dest=%0d data=%0h expected 1/4/b004", wrEn, wrDest, wrData); end
    applyStimulus();
    req1Valid = 1'b0;
    vectors++; if ({wrEn, wrDest, wrData} !== {1'b1, 3'd5, 16'hB005}) begin miscompares++; $display("[TB] FAIL hold_retire1: got en=%0b dest=%0d data=%0h expected 1/5/b005", wrEn, wrDest, wrData); end
    applyStimulus();
    vectors++; if ({wrEn, wrDest, wrData} !== {1'b1, 3'd6, 16'hB006}) begin miscompares++; $display("[TB] FAIL hold_retire2: got en=%0b dest=%0d data=%0h expected 1/6/b006", wrEn, wrDest, wrData); end
    applyStimulus();
    vectors++; if (wrEn !== 1'b0) begin miscompares++; $display("[TB] FAIL hold_drain: got %0b expected 0", wrEn); end
  endtask

  task automatic test_dest_zero();
    req0Valid = 1'b1; req0Dest = 3'd0; req0Data = 16'hFFFF;
    applyStimulus();
    req0Valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vectors++; if ({wrEn, pendingOut} !== 9'h000) begin
        miscompares++; $display("[TB] FAIL zero_dest_c%0d: got en=%0b pending=%0h expected 0/0", i, wrEn, pendingOut);
      end
      applyStimulus();
    end
  endtask

  task automatic test_full_pushpop();
    int sent = 0;
    int retired = 0;
    bit xfer;
    hold = 1'b1; req0Valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (c == 2) begin
        vectors++; if (req0Ready !== 1'b0) begin miscompares++; $display("[TB] FAIL full_ready: got %0b expected 0", req0Ready); end
        hold = 1'b0;
      end
      req0Dest = AW'(1 + (sent % 7));
      req0Data = 16'hA000 + 16'(sent);
      xfer = req0Valid && (mQ0.size() < DEPTH);
      applyStimulus();
      if (xfer) sent++;
      if (sent >= 8) req0Valid = 1'b0;
      vectors++; if ({wrEn, wrDest, wrData, req0Ready} !== {mWrEn, mWrDest, mWrData, mQ0.size() < DEPTH}) begin
        miscompares++; $display("[TB] FAIL full_cycle%0d: got en=%0b dest=%0d data=%0h rdy=%0b expected en=%0b dest=%0d data=%0h rdy=%0b",
          c, wrEn, wrDest, wrData, req0Ready, mWrEn, mWrDest, mWrData, mQ0.size() < DEPTH);
      end
      if (wrEn) begin
        vectors++; if (wrData !== 16'hA000 + 16'(retired)) begin
          miscompares++; $display("[TB] FAIL full_order%0d: got %0h expected %0h", retired, wrData, 16'hA000 + 16'(retired));
        end
        retired++;
      end
    end
    vectors++; if (retired !== 8) begin miscompares++; $display("[TB] FAIL full_retired_count: got %0d expected 8", retired); end
  endtask

  task automatic test_reset_mid();
    hold = 1'b1; req0Valid = 1'b1; req1Valid = 1'b1;
    req0Dest = 3'd2; req1Dest = 3'd7; req0Data = 16'hC002; req1Data = 16'hC007;
    applyStimulus();
    applyStimulus();
    req0Valid = 1'b0; req1Valid = 1'b0; hold = 1'b0;
    applyStimulus();
    vectors++; if (wrEn !== 1'b1) begin miscompares++; $display("[TB] FAIL mid_staged: got %0b expected 1", wrEn); end
    #2;
    rst = 1'b1;
    #1;
    modelReset();
    vectors++; if ({wrEn, pendingOut, req0Ready, req1Ready} !== {1'b0, 8'h00, 2'b11}) begin
      miscompares++; $display("[TB] FAIL mid_reset_async: got en=%0b pending=%0h ready=%b expected 0/0/11", wrEn, pendingOut, {req0Ready, req1Ready});
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus();
      vectors++; if ({wrEn, pendingOut} !== 9'h000) begin miscompares++; $display("[TB] FAIL mid_after_c%0d: got en=%0b pending=%0h expected 0/0", i, wrEn, pendingOut); end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      req0Valid = ($urandom_range(0, 99) < 55);
      req1Valid = ($urandom_range(0, 99) < 55);
      req0Dest  = AW'($urandom_range(0, 7));
      req1Dest  = AW'($urandom_range(0, 7));
      req0Data  = DW'($urandom);
      req1Data  = DW'($urandom);
      hold      = ($urandom_range(0, 99) < 20);
      applyStimulus();
      vectors++; if (wrEn !== mWrEn) begin miscompares++; $display("[TB] FAIL rand_wr_en c%0d: got %0b expected %0b", c, wrEn, mWrEn); end
      vectors++; if ({wrDest, wrData} !== {mWrDest, mWrData}) begin
        miscompares++; $display("[TB] FAIL rand_wr_port c%0d: got dest=%0d data=%0h expected dest=%0d data=%0h", c, wrDest, wrData, mWrDest, mWrData);
      end
      vectors++; if ({req0Ready, req1Ready} !== {mQ0.size() < DEPTH, mQ1.size() < DEPTH}) begin
        miscompares++; $display("[TB] FAIL rand_ready c%0d: got %b expected %b", c, {req0Ready, req1Ready}, {mQ0.size() < DEPTH, mQ1.size() < DEPTH});
      end
      vectors++; if (pendingOut !== modelPending()) begin miscompares++; $display("[TB] FAIL rand_pending c%0d: got %0h expected %0h", c, pendingOut, modelPending()); end
    end
    req0Valid = 1'b0; req1Valid = 1'b0; hold = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_hold_backpressure();
    test_dest_zero();
    test_full_pushpop();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
